arbitro_1: RTL
==============

Name: arbitro_1

Overview:
- Merge arbiter: the other end of the demux arbiter that distributes one FIFO round-robin into four.
- Collects words from four input FIFOs (one per virtual channel) and forwards them into a single output FIFO.
- Round-robin grant skips empty queues and is gated by output back-pressure.
- Includes a one-stage registered data path that matches the FIFOs' registered read (data valid the cycle after pop).

Parameters:
- DATA_WIDTH, 6, width of every FIFO word.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- state  input  4  global FSM state; 4'b0001 = INIT, any other value = active
- empty0..empty3  input  1 each  input FIFO k empty flag
- data_in0..data_in3  input  DATA_WIDTH each  input FIFO k read data, valid the cycle after pop k
- almost_full  input  1  output FIFO almost-full flag; threshold leaves room for 1 in-flight word
- pop0..pop3  output  1 each  read strobe to input FIFO k (combinational)
- push  output  1  write strobe to output FIFO (registered)
- data_out  output  DATA_WIDTH  word to output FIFO, qualified by push
- idle  output  1  high when all inputs empty and nothing in flight

Behaviour:
- Reset (clk edge with reset=1): ptr<=0, valid_q<=0, sel_q<=0. After reset: push=0, pops=0, data_out=0, idle=1 if all empty.
- INIT (state==4'b0001, reset=0):
  - pop0..3=0 and ptr<=0.
  - valid_q<=0, but a word already in flight (valid_q=1) is still pushed this cycle.
- Grant (active state, almost_full=0):
  - grant = first k with empty_k=0, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - If found: pop_grant=1, other pops 0, ptr<=grant+1 (3 wraps to 0).
  - If none: no pop, ptr holds.
- Back-pressure: almost_full=1 gives pops=0 and ptr holds; the in-flight word (valid_q) is still pushed.
- At most one pop per cycle; never pop an empty FIFO.
- Pipeline:
  - valid_q<=any pop; sel_q<=grant.
  - push=valid_q.
  - data_out=data_in[sel_q] when valid_q, else 0.
  - Latency pop->push = 1 cycle.
  - Sustained throughput: 1 word/cycle.
- Fairness:
  - Continuously non-empty queues are served 0,1,2,3,0...
  - A queue becoming non-empty waits at most 3 grants.
- Simultaneous events:
  - reset beats INIT beats almost_full.
  - empty_k rising the same cycle as a grant is honored, since the grant is combinational on current flags.
- idle = (empty0&empty1&empty2&empty3) & ~valid_q.
- ptr: 2-bit, natural mod-4 wrap.

Decomposition:
- Shared package: DATA_WIDTH default; state encodings (STATE_INIT=4'b0001, plus the other FSM codes used by the system); NUM_VC=4.
- Sub-module rr_grant4: combinational 4-way round-robin search.
  - Inputs: req[3:0] (=~empty), ptr[1:0].
  - Outputs: gnt_valid, gnt_idx[1:0].
  - Reusable by the demux arbiter if it gains skip-full logic.

Test Plan:
- Reset then all queues loaded (q0=A0,A1; q1=B0; q2=C0; q3 empty), almost_full=0 -> pops 0,1,2,0 on consecutive cycles; push sequence A0,B0,C0,A1 each 1 cycle after its pop; then idle=1.
- Only q3 non-empty (3 words), ptr=0 -> pop3 on 3 consecutive cycles; ptr stays at 0 after each grant (3+1 wraps); 3 pushes, data from data_in3.
- All queues full, almost_full rises at cycle 5 for 3 cycles -> pops stop at cycle 5; the word popped at cycle 4 is pushed at cycle 5; pops resume at the next index in rotation.
- state=4'b0001 asserted mid-stream after a pop -> that word is still pushed next cycle; no further pops; ptr=0; after return to an active state, first grant goes to the lowest non-empty index.
- reset asserted same cycle as a pop -> next cycle push=0, ptr=0, no word emitted.
- Random empty patterns over 1000 cycles, scoreboard per queue -> no pop on an empty FIFO, order preserved per queue, no grant starvation beyond 3 cycles while almost_full=0.

Source files
------------

// File: rtl/arbitro_1_pkg.sv
// Shared definitions for the four-VC merge arbiter and its neighbours.
package arbitro_1_pkg;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int NUM_VC         = 4;

    // Global FSM encodings; the arbiter only distinguishes INIT from the rest.
    typedef enum logic [3:0] {
        STATE_INIT   = 4'b0001,
        STATE_IDLE   = 4'b0010,
        STATE_ACTIVE = 4'b0100,
        STATE_ERROR  = 4'b1000
    } sys_state_e;

endpackage

// File: rtl/arbitro_1_rr_grant4.sv
// Combinational 4-way round-robin search starting at ptr.
module rr_grant4
    import arbitro_1_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            idx = ptr + 2'(i);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_1.sv
// Merge arbiter: four input FIFOs into one output FIFO, round-robin,
// skipping empty queues and stalling on output almost-full.
module arbitro_1
    import arbitro_1_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            state,
    input  logic                  empty0,
    input  logic                  empty1,
    input  logic                  empty2,
    input  logic                  empty3,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic                  almost_full,
    output logic                  pop0,
    output logic                  pop1,
    output logic                  pop2,
    output logic                  pop3,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  idle
);

    logic [1:0]            ptr;
    logic [1:0]            sel_q;
    logic                  valid_q;
    logic [NUM_VC-1:0]     req;
    logic [NUM_VC-1:0]     pop_vec;
    logic                  gnt_valid;
    logic [1:0]            gnt_idx;
    logic                  active;
    logic                  pop_any;
    logic [DATA_WIDTH-1:0] data_in_arr [NUM_VC];

    assign req         = ~{empty3, empty2, empty1, empty0};
    assign data_in_arr = '{data_in0, data_in1, data_in2, data_in3};

    rr_grant4 u_rr (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Grant is evaluated on this cycle's empty flags, so a queue that just
    // drained is never popped.
    always_comb begin
        active  = (state != STATE_INIT);
        pop_any = active && !almost_full && gnt_valid;
        pop_vec = '0;
        if (pop_any) begin
            pop_vec[gnt_idx] = 1'b1;
        end
    end

    assign {pop3, pop2, pop1, pop0} = pop_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            valid_q <= pop_any;
            sel_q   <= gnt_idx;
            if (!active) begin
                ptr <= '0;
            end else if (pop_any) begin
                ptr <= gnt_idx + 2'd1;
            end
        end
    end

    // The FIFOs register their read data, so the popped word appears on
    // data_in one cycle after the pop, aligned with valid_q.
    assign push     = valid_q;
    assign data_out = valid_q ? data_in_arr[sel_q] : '0;
    assign idle     = (&(~req)) & ~valid_q;

endmodule
